// File: rtl/csc_pkg.sv
// Shared definitions for the CSC stream codec: FSM states, error-bit positions and
// the end-of-matrix marker check.
package csc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StFill,
        StEmit,
        StTail,
        StDrain,
        StDone
    } dec_state_e;

    localparam int unsigned ErrRow  = 0;
    localparam int unsigned ErrHdr  = 1;
    localparam int unsigned ErrLast = 2;
    localparam int unsigned ErrCfg  = 3;

    // tlast must mark exactly the last consumed word of the final column.
    function automatic logic tlast_mismatch(input logic tlast, input logic last_col,
                                            input logic col_end);
        return tlast != (last_col && col_end);
    endfunction

endpackage

// File: rtl/csc_dec_out_reg.sv
// One-entry AXI-stream register slice. It accepts a new beat whenever it is empty or
// its current beat leaves in the same cycle.
module csc_dec_out_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);

    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
                last_d = in_last_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/csc_dec_stream.sv
// Streaming CSC decoder. It expands per-column (row,value) entries into a dense
// column-major element stream and zero-fills every row that has no entry.
module csc_dec_stream
    import csc_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 16
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    input  logic [IDX_W-1:0]        cfg_rows,
    input  logic [IDX_W-1:0]        cfg_cols,
    input  logic [IDX_W+DATA_W-1:0] s_axis_tdata,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_W-1:0]       m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [3:0]              err_sticky,
    output logic                    blk_in,
    output logic                    blk_out
);

    localparam logic [IDX_W-1:0] One = IDX_W'(1);

    dec_state_e       state_q, state_d;
    logic [IDX_W-1:0] rows_q, rows_d, cols_q, cols_d;
    logic [IDX_W-1:0] row_q, row_d, col_q, col_d, nnz_q, nnz_d;
    logic [3:0]       err_q, err_d;
    logic             last_seen_q, last_seen_d;

    logic [IDX_W-1:0]  in_idx;
    logic [DATA_W-1:0] in_val;
    logic              last_col, need_in, slot_free, push, push_last;
    logic [DATA_W-1:0] push_data;

    assign in_idx   = s_axis_tdata[IDX_W+DATA_W-1:DATA_W];
    assign in_val   = s_axis_tdata[DATA_W-1:0];
    assign last_col = (col_q == cols_q - One);

    always_comb begin
        state_d       = state_q;
        rows_d        = rows_q;
        cols_d        = cols_q;
        row_d         = row_q;
        col_d         = col_q;
        nnz_d         = nnz_q;
        err_d         = err_q;
        last_seen_d   = last_seen_q;
        s_axis_tready = 1'b0;
        need_in       = 1'b0;
        push          = 1'b0;
        push_data     = '0;
        push_last     = (row_q == rows_q - One) && last_col;

        unique case (state_q)
            StIdle: begin
                if (ap_start) begin
                    rows_d      = cfg_rows;
                    cols_d      = cfg_cols;
                    err_d       = '0;
                    row_d       = '0;
                    col_d       = '0;
                    nnz_d       = '0;
                    last_seen_d = 1'b0;
                    if (cfg_rows == '0 || cfg_cols == '0) begin
                        err_d[ErrCfg] = 1'b1;
                        state_d       = StDone;
                    end else begin
                        state_d = StHdr;
                    end
                end
            end
            StHdr: begin
                // After an early tlast the remaining columns are zero-filled from nothing.
                if (last_seen_q) begin
                    nnz_d   = '0;
                    state_d = StTail;
                end else begin
                    need_in       = 1'b1;
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid) begin
                        if (!s_axis_tuser) begin
                            err_d[ErrHdr] = 1'b1;
                            if (s_axis_tlast) begin
                                err_d[ErrLast] = 1'b1;
                                last_seen_d    = 1'b1;
                            end
                        end else begin
                            nnz_d = in_idx;
                            if (tlast_mismatch(s_axis_tlast, last_col, in_idx == '0)) begin
                                err_d[ErrLast] = 1'b1;
                            end
                            last_seen_d = last_seen_q || s_axis_tlast;
                            state_d     = (in_idx == '0 || s_axis_tlast) ? StTail : StFill;
                        end
                    end
                end
            end
            StFill: begin
                need_in = 1'b1;
                if (s_axis_tvalid) begin
                    if (s_axis_tuser) begin
                        // Next column's header arrived early: leave it for StHdr.
                        err_d[ErrHdr] = 1'b1;
                        state_d       = StTail;
                    end else if (in_idx < row_q || in_idx >= rows_q) begin
                        err_d[ErrRow] = 1'b1;
                        s_axis_tready = 1'b1;
                        nnz_d         = nnz_q - One;
                        if (tlast_mismatch(s_axis_tlast, last_col, nnz_q == One)) begin
                            err_d[ErrLast] = 1'b1;
                        end
                        last_seen_d = last_seen_q || s_axis_tlast;
                        if (nnz_q == One || s_axis_tlast) begin
                            state_d = StTail;
                        end
                    end else if (in_idx == row_q) begin
                        state_d = StEmit;
                    end else if (slot_free) begin
                        push  = 1'b1;
                        row_d = row_q + One;
                    end
                end
            end
            StEmit: begin
                need_in = 1'b1;
                if (s_axis_tvalid && slot_free) begin
                    s_axis_tready = 1'b1;
                    push          = 1'b1;
                    push_data     = in_val;
                    row_d         = row_q + One;
                    nnz_d         = nnz_q - One;
                    if (tlast_mismatch(s_axis_tlast, last_col, nnz_q == One)) begin
                        err_d[ErrLast] = 1'b1;
                    end
                    last_seen_d = last_seen_q || s_axis_tlast;
                    state_d     = (nnz_q == One || s_axis_tlast) ? StTail : StFill;
                end
            end
            StTail: begin
                if (row_q != rows_q && slot_free) begin
                    push  = 1'b1;
                    row_d = row_q + One;
                end
                // Advance the column on the same cycle as its final zero.
                if (row_q == rows_q || (slot_free && row_q == rows_q - One)) begin
                    row_d   = '0;
                    col_d   = col_q + One;
                    state_d = last_col ? StDrain : StHdr;
                end
            end
            StDrain: begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= StIdle;
            rows_q      <= '0;
            cols_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            nnz_q       <= '0;
            err_q       <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            row_q       <= row_d;
            col_q       <= col_d;
            nnz_q       <= nnz_d;
            err_q       <= err_d;
            last_seen_q <= last_seen_d;
        end
    end

    csc_dec_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk_i      (ap_clk),
        .rst_ni     (ap_rst_n),
        .in_valid_i (push),
        .in_ready_o (slot_free),
        .in_data_i  (push_data),
        .in_last_i  (push_last),
        .out_valid_o(m_axis_tvalid),
        .out_ready_i(m_axis_tready),
        .out_data_o (m_axis_tdata),
        .out_last_o (m_axis_tlast)
    );

    assign ap_idle    = (state_q == StIdle);
    assign ap_done    = (state_q == StDone);
    assign err_sticky = err_q;
    assign blk_in     = need_in && !s_axis_tvalid;
    assign blk_out    = m_axis_tvalid && !m_axis_tready;

endmodule
